// File: rtl/glitch_burst_gen_pkg.sv
// Shared types and default widths for the glitch burst generator.
package glitch_pkg;

    localparam int REPEAT_W_DEF = 12;
    localparam int SPACE_W_DEF  = 16;
    localparam int CNT_W_DEF    = 16;

    // Burst sequencer states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_SPENT = 3'd4
    } state_e;

endpackage

// File: rtl/glitch_burst_gen_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/glitch_burst_gen.sv
// Trigger-armed burst generator driving the clock-glitch enable.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | disarmed, trigger edges ignored
// ARMED  | waiting for a rising edge on the delayed trigger
// PULSE  | glitch_go high this cycle
// GAP    | idle cycles between two pulses of a burst
// SPENT  | oneshot burst finished, waiting for arm to drop
module glitch_burst_gen
    import glitch_pkg::*;
#(
    parameter int REPEAT_W = REPEAT_W_DEF,
    parameter int SPACE_W  = SPACE_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                arm,
    input  logic                oneshot,
    input  logic                trig_in,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic [SPACE_W-1:0]  spacing,
    output logic                glitch_go,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    trig_count,
    output logic [CNT_W-1:0]    missed_count
);

    state_e               state_q, state_d;
    logic                 trig_dly_q;
    logic [REPEAT_W-1:0]  rem_q, rem_d;
    logic [SPACE_W-1:0]   gap_cfg_q, gap_cfg_d;
    logic [SPACE_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                 glitch_go_q, glitch_go_d;
    logic                 armed_q, armed_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     trig_count_q, trig_count_d;
    logic                 trig_rise;
    logic                 trig_missed;

    // trig_dly_q resets high so a trigger already high at reset is not an edge.
    assign trig_rise = trig_in & ~trig_dly_q;

    // Edges that arrive while a burst is running or spent are counted as missed.
    assign trig_missed = trig_rise &&
                         ((state_q == S_PULSE) || (state_q == S_GAP) || (state_q == S_SPENT));

    // Next-state, burst counters and registered-output values.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        gap_cfg_d    = gap_cfg_q;
        gap_cnt_d    = gap_cnt_q;
        done_d       = 1'b0;
        trig_count_d = trig_count_q;

        if (!arm) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (trig_rise) begin
                        state_d      = S_PULSE;
                        rem_d        = (repeat_cnt == '0) ? REPEAT_W'(1) : repeat_cnt;
                        gap_cfg_d    = spacing;
                        trig_count_d = trig_count_q + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    rem_d = rem_q - REPEAT_W'(1);
                    if (rem_q <= REPEAT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = oneshot ? S_SPENT : S_ARMED;
                    end else if (gap_cfg_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_cfg_q;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q <= SPACE_W'(1)) begin
                        state_d = S_PULSE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - SPACE_W'(1);
                    end
                end
                S_SPENT: begin
                    state_d = S_SPENT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        glitch_go_d = (state_d == S_PULSE);
        armed_d     = (state_d == S_ARMED);
        busy_d      = (state_d == S_PULSE) || (state_d == S_GAP);
    end

    // State, counters, edge-detect and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            trig_dly_q   <= 1'b1;
            rem_q        <= '0;
            gap_cfg_q    <= '0;
            gap_cnt_q    <= '0;
            glitch_go_q  <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trig_count_q <= '0;
        end else begin
            state_q      <= state_d;
            trig_dly_q   <= trig_in;
            rem_q        <= rem_d;
            gap_cfg_q    <= gap_cfg_d;
            gap_cnt_q    <= gap_cnt_d;
            glitch_go_q  <= glitch_go_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            trig_count_q <= trig_count_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_missed_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (trig_missed),
        .clear   (1'b0),
        .count   (missed_count)
    );

    assign glitch_go  = glitch_go_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign trig_count = trig_count_q;

endmodule

// File: tb/tb_glitch_burst_gen.sv
// Directed, table-driven bench for glitch_burst_gen.
module tb_glitch_burst_gen;

    localparam int REPEAT_W = 12;
    localparam int SPACE_W  = 16;
    localparam int CNT_W    = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                arm;
    logic                oneshot;
    logic                trig_in;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic [SPACE_W-1:0]  spacing;
    logic                glitch_go;
    logic                armed;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    trig_count;
    logic [CNT_W-1:0]    missed_count;

    int n_checks = 0;
    int n_fail   = 0;

    glitch_burst_gen #(
        .REPEAT_W (REPEAT_W),
        .SPACE_W  (SPACE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arm          (arm),
        .oneshot      (oneshot),
        .trig_in      (trig_in),
        .repeat_cnt   (repeat_cnt),
        .spacing      (spacing),
        .glitch_go    (glitch_go),
        .armed        (armed),
        .busy         (busy),
        .done         (done),
        .trig_count   (trig_count),
        .missed_count (missed_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  n;
        logic                arm;
        logic                os;
        logic                trig;
        logic [REPEAT_W-1:0] rpt;
        logic [SPACE_W-1:0]  spc;
        logic                go;
        logic                ar;
        logic                bs;
        logic                dn;
        logic [CNT_W-1:0]    tc;
        logic [CNT_W-1:0]    mc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic a, logic os, logic t, int rpt, int spc,
                                logic go, logic ar, logic bs, logic dn, int tc, int mc);
        vec_t v;
        v.n = n; v.arm = a; v.os = os; v.trig = t;
        v.rpt = REPEAT_W'(rpt); v.spc = SPACE_W'(spc);
        v.go = go; v.ar = ar; v.bs = bs; v.dn = dn;
        v.tc = CNT_W'(tc); v.mc = CNT_W'(mc);
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {12'd0, glitch_go, armed, busy, done, trig_count, missed_count};
    endfunction

    initial begin
        //   n arm os trig rpt spc | go ar bs dn tc mc
        // reset released with arm=1, trig high: no edge
        add(1, 1, 0, 1, 3, 2,   0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 3, 2,   0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 3, 2,   0, 1, 0, 0, 0, 0);
        // repeat=3 spacing=2: pulses k, k+3, k+6, done k+7
        add(1, 1, 0, 1, 3, 2,   1, 0, 1, 0, 1, 0);
        add(2, 1, 0, 0, 3, 2,   0, 0, 1, 0, 1, 0);
        add(1, 1, 0, 0, 3, 2,   1, 0, 1, 0, 1, 0);
        add(2, 1, 0, 0, 3, 2,   0, 0, 1, 0, 1, 0);
        add(1, 1, 0, 0, 3, 2,   1, 0, 1, 0, 1, 0);
        add(1, 1, 0, 0, 3, 2,   0, 1, 0, 1, 1, 0);
        add(1, 1, 0, 0, 3, 2,   0, 1, 0, 0, 1, 0);
        // repeat=0 treated as 1
        add(1, 1, 0, 1, 0, 0,   1, 0, 1, 0, 2, 0);
        add(1, 1, 0, 0, 0, 0,   0, 1, 0, 1, 2, 0);
        add(1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 2, 0);
        // repeat=4 back-to-back; config changes mid-burst ignored
        add(1, 1, 0, 1, 4, 0,   1, 0, 1, 0, 3, 0);
        add(3, 1, 0, 0, 1, 5,   1, 0, 1, 0, 3, 0);
        add(1, 1, 0, 0, 1, 5,   0, 1, 0, 1, 3, 0);
        // repeat=5 spacing=3 with a missed edge inside the first gap
        add(1, 1, 0, 1, 5, 3,   1, 0, 1, 0, 4, 0);
        add(1, 1, 0, 0, 5, 3,   0, 0, 1, 0, 4, 0);
        add(1, 1, 0, 1, 5, 3,   0, 0, 1, 0, 4, 1);
        add(1, 1, 0, 0, 5, 3,   0, 0, 1, 0, 4, 1);
        add(1, 1, 0, 0, 5, 3,   1, 0, 1, 0, 4, 1);
        add(3, 1, 0, 0, 5, 3,   0, 0, 1, 0, 4, 1);
        add(1, 1, 0, 0, 5, 3,   1, 0, 1, 0, 4, 1);
        add(3, 1, 0, 0, 5, 3,   0, 0, 1, 0, 4, 1);
        add(1, 1, 0, 0, 5, 3,   1, 0, 1, 0, 4, 1);
        add(3, 1, 0, 0, 5, 3,   0, 0, 1, 0, 4, 1);
        add(1, 1, 0, 0, 5, 3,   1, 0, 1, 0, 4, 1);
        add(1, 1, 0, 0, 5, 3,   0, 1, 0, 1, 4, 1);
        // retrigger sampled at the end of the done cycle
        add(1, 1, 0, 1, 1, 0,   1, 0, 1, 0, 5, 1);
        add(1, 1, 0, 0, 1, 0,   0, 1, 0, 1, 5, 1);
        // oneshot: SPENT, missed edge, rearm via arm low
        add(1, 1, 1, 1, 2, 1,   1, 0, 1, 0, 6, 1);
        add(1, 1, 1, 0, 2, 1,   0, 0, 1, 0, 6, 1);
        add(1, 1, 1, 0, 2, 1,   1, 0, 1, 0, 6, 1);
        add(1, 1, 1, 0, 2, 1,   0, 0, 0, 1, 6, 1);
        add(1, 1, 1, 1, 2, 1,   0, 0, 0, 0, 6, 2);
        add(1, 1, 1, 0, 2, 1,   0, 0, 0, 0, 6, 2);
        add(1, 0, 1, 0, 2, 1,   0, 0, 0, 0, 6, 2);
        add(1, 1, 1, 0, 2, 1,   0, 1, 0, 0, 6, 2);
        add(1, 1, 1, 1, 2, 1,   1, 0, 1, 0, 7, 2);
        add(1, 1, 1, 0, 2, 1,   0, 0, 1, 0, 7, 2);
        // arm dropped during GAP: no pulse, no done; IDLE edges not counted
        add(1, 0, 1, 0, 2, 1,   0, 0, 0, 0, 7, 2);
        add(1, 0, 1, 1, 2, 1,   0, 0, 0, 0, 7, 2);
        add(1, 1, 1, 0, 2, 1,   0, 1, 0, 0, 7, 2);
        add(2, 1, 1, 0, 2, 1,   0, 1, 0, 0, 7, 2);

        reset_n = 1'b0; arm = 1'b1; oneshot = 1'b0; trig_in = 1'b1;
        repeat_cnt = 12'd3; spacing = 16'd2;
        repeat (3) step();
        check("reset_outputs", pack_out(), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            arm = vecs[i].arm; oneshot = vecs[i].os; trig_in = vecs[i].trig;
            repeat_cnt = vecs[i].rpt; spacing = vecs[i].spc;
            for (int j = 0; j < vecs[i].n; j++) begin
                step();
                check($sformatf("row%0d_cyc%0d", i, j), pack_out(),
                      {12'd0, vecs[i].go, vecs[i].ar, vecs[i].bs, vecs[i].dn,
                       vecs[i].tc, vecs[i].mc});
            end
        end

        // Saturation of missed_count while SPENT.
        begin
            int go_seen;
            go_seen = 0;
            oneshot = 1'b1; repeat_cnt = 12'd1; spacing = 16'd0; trig_in = 1'b1;
            step();
            check("sat_fire_go", {31'd0, glitch_go}, 32'd1);
            check("sat_fire_tc", {24'd0, trig_count}, 32'd8);
            trig_in = 1'b0;
            step();
            check("sat_spent_done", {30'd0, done, armed}, 32'b10);
            for (int i = 0; i < 300; i++) begin
                trig_in = 1'b1;
                step();
                if (glitch_go) go_seen++;
                trig_in = 1'b0;
                step();
                if (glitch_go) go_seen++;
                if (i == 99) check("missed_mid", {24'd0, missed_count}, 32'd102);
            end
            check("missed_saturated", {24'd0, missed_count}, 32'd255);
            check("spent_no_go", go_seen, 32'd0);
            check("spent_tc_held", {24'd0, trig_count}, 32'd8);
            arm = 1'b0;
            step();
            check("disarm_idle", {30'd0, armed, busy}, 32'd0);
            arm = 1'b1;
            step();
            check("rearm_armed", {31'd0, armed}, 32'd1);
            check("missed_still_sat", {24'd0, missed_count}, 32'd255);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_burst_gen.md
# glitch_burst_gen

Downstream consumer of the resynchronised external trigger in the clock-glitch path. Waits armed for a rising edge on the delayed trigger, then emits a burst of single-cycle glitch-enable pulses with programmable count and spacing. Output drives the glitch generator's enable. Also reports arm/busy status and trigger statistics to the register block.

## Interface
Parameters:
- REPEAT_W, 12, width of pulse-count config
- SPACE_W, 16, width of inter-pulse gap config
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  single system clock, all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- arm  in  1  level; 1 = enable, 0 = force IDLE (aborts burst)
- oneshot  in  1  1 = fire one burst per arm assertion
- trig_in  in  1  resynchronised, delayed trigger (exttrigger_resync)
- repeat_cnt  in  REPEAT_W  pulses per burst; 0 treated as 1
- spacing  in  SPACE_W  idle cycles between pulses; 0 = back-to-back
- glitch_go  out  1  registered glitch enable, one cycle per pulse
- armed  out  1  state == ARMED
- busy  out  1  state == PULSE or GAP
- done  out  1  one-cycle strobe after last pulse of a burst
- trig_count  out  CNT_W  accepted triggers, wraps
- missed_count  out  CNT_W  triggers edges while busy/SPENT, saturates at all-ones

## Operation
- States: IDLE, ARMED, PULSE, GAP, SPENT.
- Edge detect: trig_rise = trig_in & ~trig_d; trig_d resets to 1, so trig_in high at reset is not an edge.
- IDLE: arm=1 -> ARMED.
- ARMED: trig_rise -> PULSE; latch repeat_cnt (0→1) into rem and spacing into gap_cfg; trig_count++.
- PULSE (glitch_go=1, one cycle): rem-1. If rem==1 -> done; then ARMED (oneshot=0) or SPENT (oneshot=1). Else spacing==0 stays PULSE; else GAP with gap counter = gap_cfg.
- GAP: decrement; at 1 -> PULSE.
- SPENT: hold until arm=0 -> IDLE.
- arm=0 in any state -> IDLE at next edge; glitch_go low from that cycle; no done strobe.
- trig_rise in PULSE, GAP, SPENT: not accepted; missed_count++ (saturating). Edges in IDLE ignored, not counted.
- Config inputs changing mid-burst have no effect (latched).
- Reset: state IDLE; glitch_go, armed, busy, done = 0; trig_count, missed_count = 0; trig_d = 1.

## Timing
- trig_rise sampled at edge k -> glitch_go high cycle k+1 (latency 1).
- Pulse n (0-based) in cycle k+1+n·(1+spacing).
- Burst length repeat + (repeat−1)·spacing cycles; done high in cycle after last glitch_go.
- State is ARMED during the done cycle; trig_rise then is accepted (retrigger gap min 1 cycle).
- arm 0->1 in IDLE: armed=1 next cycle; trigger accepted from that cycle.
- All outputs registered; no combinational path input->output.

## Structure
- Shared package glitch_pkg: state enum (IDLE, ARMED, PULSE, GAP, SPENT), default widths.
- One sub-module: sat_counter (CNT_W, inc, clear, saturating), used for missed_count; trig_count a plain wrapping counter inline.
- FSM, rem and gap counters, edge detect inline.

## Test plan
- Reset with trig_in=1, arm=1: no glitch_go; armed=1 after release; trig_count=0.
- repeat=3, spacing=2, trig pulse at edge k: glitch_go at k+1, k+4, k+7; done at k+8; trig_count=1.
- repeat=0, spacing=0: exactly one glitch_go cycle; repeat=4, spacing=0: four consecutive cycles.
- Second trig_in pulse mid-burst (repeat=5, spacing=3): ignored, missed_count=1; trigger in done cycle accepted, new burst starts next cycle.
- oneshot=1: after burst state SPENT, further trigger -> missed_count++ and no glitch_go; arm 0 then 1 rearms.
- arm dropped during GAP: glitch_go stays low, no done, IDLE next cycle; missed_count held at 0xFFFF after 70000 missed edges.
